// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT: window offsets, reset constants, the
// register-select enum and byte select/insert helpers for the
// little-endian byte-serial access port.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
  localparam logic [63:0] MTIMECMP_RST       = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } clint_reg_e;

  // Byte off of a 64-bit register; byte 0 holds bits [7:0].
  function automatic logic [7:0] byte_sel(input logic [63:0] v, input logic [2:0] off);
    byte_sel = v[{off, 3'b000} +: 8];
  endfunction

  // v with byte off replaced by b, all other bytes unchanged.
  function automatic logic [63:0] byte_ins(input logic [63:0] v, input logic [2:0] off,
                                           input logic [7:0] b);
    byte_ins = v;
    byte_ins[{off, 3'b000} +: 8] = b;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// Ports: i_clk, i_rst_n (async, active low), o_tick (high in the wrap cycle;
// with TICK_DIV=1 it is high every cycle).
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = o_tick ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_mem.sv
// Core-local interruptor on the byte-serial submodule port of memory_top.
// Holds mtime (free running, prescaled), mtimecmp and msip; every i_request
// is answered by exactly one o_data_DV pulse in the following cycle.
// Ports: i_clk, i_rst_n (async, active low); i_data/i_address/i_write/
// i_request byte access from memory_top; o_data/o_data_DV response;
// o_timer_interrupt (mtime >= mtimecmp, registered); o_software_interrupt
// (msip bit 0).
// Optional feature macro CLINT_SNAPSHOT_EN: reading mtime byte 0 latches a
// 64-bit shadow copy, and mtime bytes 1..7 then read from the shadow so a
// multi-byte read is tear-free. Without it every mtime byte reads live.
module clint_mem
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_write,
  input  logic              i_request,
  output logic [7:0]        o_data,
  output logic              o_data_DV,
  output logic              o_timer_interrupt,
  output logic              o_software_interrupt
);

  localparam logic [ADDR_W-1:0] MSIP_BASE  = ADDR_W'(CLINT_MSIP_OFF);
  localparam logic [ADDR_W-1:0] CMP_BASE   = ADDR_W'(CLINT_MTIMECMP_OFF);
  localparam logic [ADDR_W-1:0] MTIME_BASE = ADDR_W'(CLINT_MTIME_OFF);

  logic        tick;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        dv_q, dv_d;
  logic        tirq_q, tirq_d;
`ifdef CLINT_SNAPSHOT_EN
  logic [63:0] shadow_q, shadow_d;
`endif

  clint_reg_e  sel;
  logic [2:0]  off;
  logic        wr, rd;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  assign off = i_address[2:0];
  assign wr  = i_request & i_write;
  assign rd  = i_request & ~i_write;

  // msip occupies a 4-byte slot, the 64-bit registers 8-byte slots.
  always_comb begin
    sel = REG_NONE;
    if      ((i_address >> 2) == (MSIP_BASE >> 2))  sel = REG_MSIP;
    else if ((i_address >> 3) == (CMP_BASE >> 3))   sel = REG_MTIMECMP;
    else if ((i_address >> 3) == (MTIME_BASE >> 3)) sel = REG_MTIME;
  end

  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = 8'h00;
    dv_d       = i_request;
    tirq_d     = (mtime_q >= mtimecmp_q);
`ifdef CLINT_SNAPSHOT_EN
    shadow_d   = shadow_q;
`endif

    // A byte write to mtime overrides the increment for that cycle; the
    // prescaler keeps running.
    if (wr) begin
      case (sel)
        REG_MSIP:     if (off[1:0] == 2'd0) msip_d = i_data[0];
        REG_MTIMECMP: mtimecmp_d = byte_ins(mtimecmp_q, off, i_data);
        REG_MTIME:    mtime_d    = byte_ins(mtime_q, off, i_data);
        default:      ;
      endcase
    end

    if (rd) begin
      case (sel)
        REG_MSIP:     rdata_d = (off[1:0] == 2'd0) ? {7'd0, msip_q} : 8'h00;
        REG_MTIMECMP: rdata_d = byte_sel(mtimecmp_q, off);
`ifdef CLINT_SNAPSHOT_EN
        REG_MTIME: begin
          if (off == 3'd0) begin
            rdata_d  = byte_sel(mtime_q, 3'd0);
            shadow_d = mtime_q;
          end else begin
            rdata_d  = byte_sel(shadow_q, off);
          end
        end
`else
        REG_MTIME:    rdata_d = byte_sel(mtime_q, off);
`endif
        default:      rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      rdata_q    <= 8'h00;
      dv_q       <= 1'b0;
      tirq_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      dv_q       <= dv_d;
      tirq_q     <= tirq_d;
    end
  end

`ifdef CLINT_SNAPSHOT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) shadow_q <= 64'd0;
    else          shadow_q <= shadow_d;
  end
`endif

  assign o_data               = rdata_q;
  assign o_data_DV            = dv_q;
  assign o_timer_interrupt    = tirq_q;
  assign o_software_interrupt = msip_q;

endmodule

// File: tb/tb_clint_mem.sv
module tb_clint_mem;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_data;
  logic [15:0] i_address;
  logic        i_write;
  logic        i_request;
  logic [7:0]  o_data;
  logic        o_data_DV;
  logic        o_timer_interrupt;
  logic        o_software_interrupt;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;  // clock edges since reset release (= mtime while unwritten)

  clint_mem #(.TICK_DIV(1), .ADDR_W(16)) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_data               (i_data),
    .i_address            (i_address),
    .i_write              (i_write),
    .i_request            (i_request),
    .o_data               (o_data),
    .o_data_DV            (o_data_DV),
    .o_timer_interrupt    (o_timer_interrupt),
    .o_software_interrupt (o_software_interrupt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic drive(input logic w, input logic [15:0] a, input logic [7:0] d);
    i_request = 1'b1; i_write = w; i_address = a; i_data = d;
  endtask

  task automatic idle();
    i_request = 1'b0; i_write = 1'b0; i_address = 16'h0; i_data = 8'h0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b exp 0", o_data_DV); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", o_data); end
    checks++; if (o_timer_interrupt !== 1'b0) begin errors++; $display("FAIL rst_tirq: got %b exp 0", o_timer_interrupt); end
    checks++; if (o_software_interrupt !== 1'b0) begin errors++; $display("FAIL rst_sirq: got %b exp 0", o_software_interrupt); end
    i_rst_n = 1'b1;
  endtask

  // mtime byte 0 read after 4 clock edges since release -> 0x04.
  task automatic test_read_mtime();
    repeat (4) @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b0) begin errors++; $display("FAIL rd_pre_dv: got %b exp 0", o_data_DV); end
    drive(1'b0, 16'hBFF8, 8'h00);
    @(negedge i_clk);
    idle();
    checks++; if (o_data_DV !== 1'b1) begin errors++; $display("FAIL rd_dv: got %b exp 1", o_data_DV); end
    checks++; if (o_data !== 8'h04) begin errors++; $display("FAIL rd_mtime_b0: got %h exp 04", o_data); end
    checks++; if (o_timer_interrupt !== 1'b0) begin errors++; $display("FAIL rd_tirq: got %b exp 0", o_timer_interrupt); end
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b0) begin errors++; $display("FAIL rd_dv_1cyc: got %b exp 0", o_data_DV); end
  endtask

  // mtimecmp = 0x20; interrupt first seen the cycle after mtime == 0x20.
  task automatic test_mtimecmp();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h4000 + 16'(i), (i == 0) ? 8'h20 : 8'h00);
      @(negedge i_clk);
      checks++; if (o_data_DV !== 1'b1 || o_data !== 8'h00) begin
        errors++; $display("FAIL cmp_wr_resp[%0d]: got dv=%b data=%h exp dv=1 data=00", i, o_data_DV, o_data); end
    end
    idle();
    for (int k = 0; k < 100 && cyc != 32; k++) @(negedge i_clk);
    checks++; if (cyc != 32) begin errors++; $display("FAIL cmp_wait: got cyc %0d exp 32", cyc); end
    checks++; if (o_timer_interrupt !== 1'b0) begin errors++; $display("FAIL cmp_tirq_at_eq: got %b exp 0", o_timer_interrupt); end
    @(negedge i_clk);
    checks++; if (o_timer_interrupt !== 1'b1) begin errors++; $display("FAIL cmp_tirq_rise: got %b exp 1", o_timer_interrupt); end
  endtask

  task automatic test_msip();
    drive(1'b1, 16'h0000, 8'h01);
    @(negedge i_clk);
    checks++; if (o_software_interrupt !== 1'b1) begin errors++; $display("FAIL msip_set: got %b exp 1", o_software_interrupt); end
    drive(1'b0, 16'h0000, 8'h00);
    @(negedge i_clk);
    checks++; if (o_data !== 8'h01) begin errors++; $display("FAIL msip_rd0: got %h exp 01", o_data); end
    drive(1'b0, 16'h0001, 8'h00);
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b1 || o_data !== 8'h00) begin
      errors++; $display("FAIL msip_rd1: got dv=%b data=%h exp dv=1 data=00", o_data_DV, o_data); end
    drive(1'b1, 16'h0000, 8'h00);
    @(negedge i_clk);
    idle();
    checks++; if (o_software_interrupt !== 1'b0) begin errors++; $display("FAIL msip_clr: got %b exp 0", o_software_interrupt); end
  endtask

  // Set mtime to all-ones byte by byte; it must wrap to 0 on the next tick.
  task automatic test_mtime_wrap();
    drive(1'b1, 16'hBFFF, 8'hFF);
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b1) begin errors++; $display("FAIL wrap_wr7_dv: got %b exp 1", o_data_DV); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'hBFF8 + 16'(i), 8'hFF);
      @(negedge i_clk);
      checks++; if (o_data_DV !== 1'b1 || o_data !== 8'h00) begin
        errors++; $display("FAIL wrap_wr_resp[%0d]: got dv=%b data=%h exp dv=1 data=00", i, o_data_DV, o_data); end
    end
    drive(1'b0, 16'hBFFF, 8'h00);  // samples all-ones
    @(negedge i_clk);
    checks++; if (o_data !== 8'hFF) begin errors++; $display("FAIL wrap_b7_ones: got %h exp FF", o_data); end
    checks++; if (o_timer_interrupt !== 1'b1) begin errors++; $display("FAIL wrap_tirq_hi: got %b exp 1", o_timer_interrupt); end
    drive(1'b0, 16'hBFF8, 8'h00);  // samples wrapped 0
    @(negedge i_clk);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL wrap_b0_zero: got %h exp 00", o_data); end
    checks++; if (o_timer_interrupt !== 1'b0) begin errors++; $display("FAIL wrap_tirq_lo: got %b exp 0", o_timer_interrupt); end
    drive(1'b0, 16'hBFF8, 8'h00);  // samples 1
    @(negedge i_clk);
    idle();
    checks++; if (o_data !== 8'h01) begin errors++; $display("FAIL wrap_b0_one: got %h exp 01", o_data); end
  endtask

  task automatic test_unmapped_and_reset();
    drive(1'b0, 16'h1234, 8'h00);
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b1 || o_data !== 8'h00) begin
      errors++; $display("FAIL unm_rd: got dv=%b data=%h exp dv=1 data=00", o_data_DV, o_data); end
    drive(1'b1, 16'h1234, 8'hAB);
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b1 || o_data !== 8'h00) begin
      errors++; $display("FAIL unm_wr: got dv=%b data=%h exp dv=1 data=00", o_data_DV, o_data); end
    drive(1'b0, 16'h4000, 8'h00);
    @(negedge i_clk);
    checks++; if (o_data !== 8'h20) begin errors++; $display("FAIL unm_cmp_keep: got %h exp 20", o_data); end
    checks++; if (o_software_interrupt !== 1'b0) begin errors++; $display("FAIL unm_msip_keep: got %b exp 0", o_software_interrupt); end
    drive(1'b1, 16'h0000, 8'h01);
    @(negedge i_clk);
    checks++; if (o_software_interrupt !== 1'b1) begin errors++; $display("FAIL pre_rst_msip: got %b exp 1", o_software_interrupt); end
    // Request in flight when reset hits: its response must never appear.
    drive(1'b0, 16'h4000, 8'h00);
    #2 i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 idle();
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b0 || o_data !== 8'h00) begin
      errors++; $display("FAIL rst_drop: got dv=%b data=%h exp dv=0 data=00", o_data_DV, o_data); end
    checks++; if (o_software_interrupt !== 1'b0 || o_timer_interrupt !== 1'b0) begin
      errors++; $display("FAIL rst_irqs: got sw=%b tm=%b exp 0 0", o_software_interrupt, o_timer_interrupt); end
    i_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      checks++; if (o_data_DV !== 1'b0) begin errors++; $display("FAIL rst_no_pulse[%0d]: got %b exp 0", k, o_data_DV); end
    end
  endtask

  // mtime byte0 <- FF, read BFF8 (FF), idle, read BFF9 with live mtime 0x101.
  task automatic test_snapshot();
    logic [7:0] exp_b1;
`ifdef CLINT_SNAPSHOT_EN
    exp_b1 = 8'h00;
`else
    exp_b1 = 8'h01;
`endif
    drive(1'b1, 16'hBFF8, 8'hFF);
    @(negedge i_clk);
    checks++; if (o_data_DV !== 1'b1) begin errors++; $display("FAIL snap_wr_dv: got %b exp 1", o_data_DV); end
    drive(1'b0, 16'hBFF8, 8'h00);
    @(negedge i_clk);
    idle();
    checks++; if (o_data !== 8'hFF) begin errors++; $display("FAIL snap_b0: got %h exp FF", o_data); end
    @(negedge i_clk);
    drive(1'b0, 16'hBFF9, 8'h00);
    @(negedge i_clk);
    idle();
    checks++; if (o_data !== exp_b1) begin errors++; $display("FAIL snap_b1: got %h exp %h", o_data, exp_b1); end
  endtask

  initial begin
    idle();
    test_reset();
    test_read_mtime();
    test_mtimecmp();
    test_msip();
    test_mtime_wrap();
    test_unmapped_and_reset();
    test_snapshot();
    @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_mem.md
Name: clint_mem

Overview:
- Core-local interruptor (CLINT) peripheral on the byte-serial submodule port of memory_top.
- Acts as the responder: it answers the per-byte i_request strobes that memory_top issues, just as the existing cache/uart/plic submodules do.
- Provides a free-running 64-bit mtime, a 64-bit mtimecmp and an msip bit.
- Drives the machine timer and machine software interrupt lines to the core.

Parameters:
TICK_DIV, 1, clock cycles per mtime increment; legal range is 1..65535.
ADDR_W, 16, width of the byte offset into the CLINT window.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  8  write byte from memory_top
i_address  in  ADDR_W  byte offset within the CLINT window
i_write  in  1  1 = write, 0 = read; qualified by i_request
i_request  in  1  single-cycle byte-access strobe
o_data  out  8  read byte; valid only while o_data_DV=1
o_data_DV  out  1  single-cycle response pulse
o_timer_interrupt  out  1  machine timer interrupt, level
o_software_interrupt  out  1  machine software interrupt, level (msip[0])

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - mtime=0, prescaler=0, msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - o_data=0, o_data_DV=0, o_timer_interrupt=0, o_software_interrupt=0.
  - A response pending when reset asserts is dropped; no pulse is emitted after reset.
- Byte map (little-endian: the lowest offset holds bits [7:0]):
  - 0x0000..0x0003: msip. Only bit 0 is writable; all other bits read 0.
  - 0x4000..0x4007: mtimecmp, bytes 0..7.
  - 0xBFF8..0xBFFF: mtime, bytes 0..7.
  - Any other offset reads 8'h00; writes to it are ignored.
- Handshake:
  - Every i_request produces exactly one o_data_DV pulse in the following cycle. Latency is fixed at 1 and applies to reads, writes and unmapped offsets alike, because memory_top waits on a response for writes too.
  - o_data_DV is high for exactly 1 cycle and never asserts without a preceding request.
  - On writes, o_data=8'h00. On reads, o_data = the register byte sampled in the request cycle.
  - A request arriving in the same cycle as an outgoing o_data_DV is accepted; its pulse follows in the next cycle (1 access/cycle throughput).
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - On wrap, mtime <= mtime+1 (64-bit, modulo 2^64); 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - With TICK_DIV=1, mtime increments every cycle.
- mtime write:
  - The addressed byte takes i_data; the other 7 bytes hold their value.
  - The increment is suppressed in that cycle. The prescaler is not reset.
- Multi-byte writes are not atomic. Software writes mtimecmp high word = all-ones first, then low word, then high word.
- o_timer_interrupt is registered: (mtime >= mtimecmp), unsigned, evaluated on the current register values. It lags a register change by 1 cycle.
- o_software_interrupt is registered from msip[0] and follows a write by 1 cycle.

Optional Feature:
- Macro: CLINT_SNAPSHOT_EN.
- When defined:
  - A read of offset 0xBFF8 returns live mtime byte 0 and latches all 64 bits of mtime into a shadow register.
  - Reads of 0xBFF9..0xBFFF return shadow bytes, so a word or doubleword read is tear-free.
  - Shadow resets to 0. mtime writes do not update the shadow.
- When undefined: every mtime byte reads live and there is no shadow register.

Decomposition:
- Shared package (clint_pkg) holds:
  - offsets: CLINT_MSIP_OFF=16'h0000, CLINT_MTIMECMP_OFF=16'h4000, CLINT_MTIME_OFF=16'hBFF8;
  - reset constant MTIMECMP_RST = all-ones;
  - the byte-select helper (offset[2:0] -> bit slice).
- One natural sub-module: clint_prescaler. It takes i_clk, i_rst_n and TICK_DIV, and outputs a 1-cycle o_tick.
- Decode, registers and response logic stay in clint_mem.

Test Plan:
1. Reset, TICK_DIV=1, read 0xBFF8 -> o_data_DV exactly 1 cycle after i_request; o_data = low byte of the cycle count since reset release; o_timer_interrupt=0.
2. Write bytes 0x4000..0x4007 = 0x20,0,0,0,0,0,0,0 -> o_timer_interrupt rises exactly 1 cycle after mtime reaches 0x20 (first cycle mtime >= 0x20); a DV pulse follows every write byte with o_data=0.
3. Write 0x01 to 0x0000 -> o_software_interrupt=1 one cycle later; write 0x00 -> 0; read 0x0001 -> 0x00.
4. Write mtime byte 0xBFFF=0xFF with the other bytes at 0, then write 0xBFF8..0xBFFE=0xFF -> mtime wraps to 0 on the next tick; o_timer_interrupt follows the compare against mtimecmp.
5. Read 0x1234 and write 0x1234 -> both pulse DV with o_data=0x00; no register changes; assert i_rst_n low in the cycle of a request -> no DV pulse afterwards and all outputs at reset values.
6. CLINT_SNAPSHOT_EN, TICK_DIV=1 with mtime=0x0000_00FF: read 0xBFF8 then 0xBFF9 two cycles later -> bytes 0xFF, 0x00 (shadow). Without the macro, the same sequence returns byte 1 = 0x01.
